// File: rtl/ddr_cmd_arbiter_if.sv
// Command-port bundle between the two clients, the MIG port-0 command FIFO and ddr_cmd_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface ddr_cmd_arbiter_if;
    logic        c3_calib_done;

    logic        wr_req;
    logic [5:0]  wr_bl;
    logic [29:0] wr_addr;
    logic        wr_ack;

    logic        rd_req;
    logic [5:0]  rd_bl;
    logic [29:0] rd_addr;
    logic        rd_ack;

    logic        c3_p0_cmd_en;
    logic [2:0]  c3_p0_cmd_instr;
    logic [5:0]  c3_p0_cmd_bl;
    logic [29:0] c3_p0_cmd_byte_addr;
    logic        c3_p0_cmd_full;
    logic [6:0]  c3_p0_wr_count;
    logic        c3_p0_wr_underrun;
    logic [6:0]  c3_p0_rd_count;
    logic        c3_p0_rd_overflow;

    logic        err;
    logic        refresh_missed;

    modport slave (
        input  c3_calib_done,
        input  wr_req, wr_bl, wr_addr,
        output wr_ack,
        input  rd_req, rd_bl, rd_addr,
        output rd_ack,
        output c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
        input  c3_p0_cmd_full, c3_p0_wr_count, c3_p0_wr_underrun,
        input  c3_p0_rd_count, c3_p0_rd_overflow,
        output err, refresh_missed
    );

    modport master (
        output c3_calib_done,
        output wr_req, wr_bl, wr_addr,
        input  wr_ack,
        output rd_req, rd_bl, rd_addr,
        input  rd_ack,
        input  c3_p0_cmd_en, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr,
        output c3_p0_cmd_full, c3_p0_wr_count, c3_p0_wr_underrun,
        output c3_p0_rd_count, c3_p0_rd_overflow,
        input  err, refresh_missed
    );
endinterface

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin write/read command arbiter for MIG port 0, one command per IDLE/ISSUE/GAP round.
// Define DDR_ARB_REFRESH_EN to add the periodic refresh injector (refresh_missed tied 0 otherwise).
module ddr_cmd_arbiter #(
    parameter int unsigned REFRESH_PERIOD = 3120,
    parameter int unsigned AUTO_PRECHARGE = 1
) (
    input logic              clk,
    input logic              rst_n,
    ddr_cmd_arbiter_if.slave bus
);

    localparam logic [2:0] InstrWr  = (AUTO_PRECHARGE != 0) ? 3'b010 : 3'b000;
    localparam logic [2:0] InstrRd  = (AUTO_PRECHARGE != 0) ? 3'b011 : 3'b001;
    localparam logic [2:0] InstrRef = 3'b100;

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e      state_q, state_d;
    logic        cmd_en_q, cmd_en_d;
    logic [2:0]  instr_q, instr_d;
    logic [5:0]  bl_q, bl_d;
    logic [27:0] addr_q, addr_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic        last_wr_q, last_wr_d;
    logic        err_q, err_d;

    logic        wr_elig, rd_elig, pick_wr;
    logic [6:0]  wr_need;
    logic [7:0]  rd_total;
    logic        ref_want;

    // Writes need the whole burst already in the write FIFO; reads need room for it in the read FIFO.
    assign wr_need  = {1'b0, bus.wr_bl} + 7'd1;
    assign wr_elig  = bus.wr_req && (bus.c3_p0_wr_count >= wr_need);
    assign rd_total = {1'b0, bus.c3_p0_rd_count} + {2'b00, bus.rd_bl} + 8'd1;
    assign rd_elig  = bus.rd_req && (rd_total <= 8'd64);
    assign pick_wr  = wr_elig && (!rd_elig || !last_wr_q);

    always_comb begin
        state_d   = state_q;
        cmd_en_d  = 1'b0;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        instr_d   = instr_q;
        bl_d      = bl_q;
        addr_d    = addr_q;
        last_wr_d = last_wr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.c3_calib_done && !bus.c3_p0_cmd_full &&
                    (ref_want || wr_elig || rd_elig)) begin
                    state_d  = StIssue;
                    cmd_en_d = 1'b1;
                    if (ref_want) begin
                        instr_d = InstrRef;
                        bl_d    = '0;
                        addr_d  = '0;
                    end else if (pick_wr) begin
                        instr_d  = InstrWr;
                        bl_d     = bus.wr_bl;
                        addr_d   = bus.wr_addr[29:2];
                        wr_ack_d = 1'b1;
                    end else begin
                        instr_d  = InstrRd;
                        bl_d     = bus.rd_bl;
                        addr_d   = bus.rd_addr[29:2];
                        rd_ack_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                state_d = StGap;
                if (wr_ack_q || rd_ack_q) begin
                    last_wr_d = wr_ack_q;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign err_d = err_q || bus.c3_p0_wr_underrun || bus.c3_p0_rd_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cmd_en_q  <= 1'b0;
            instr_q   <= '0;
            bl_q      <= '0;
            addr_q    <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            last_wr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_en_q  <= cmd_en_d;
            instr_q   <= instr_d;
            bl_q      <= bl_d;
            addr_q    <= addr_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            last_wr_q <= last_wr_d;
            err_q     <= err_q ? 1'b1 : err_d;
        end
    end

`ifdef DDR_ARB_REFRESH_EN
    localparam int unsigned CntW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_PERIOD - 1);

    logic [CntW-1:0] ref_cnt_q, ref_cnt_d;
    logic            ref_pend_q, ref_pend_d;
    logic            missed_q, missed_d;
    logic            ref_tick, ref_clear;

    // A refresh in flight is recognisable from the latched instruction; no client uses 3'b100.
    assign ref_clear = (state_q == StIssue) && (instr_q == InstrRef);
    assign ref_want  = ref_pend_q;

    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        ref_tick   = 1'b0;
        ref_pend_d = ref_pend_q;
        missed_d   = missed_q;
        if (bus.c3_calib_done) begin
            if (ref_cnt_q == CntLast) begin
                ref_cnt_d = '0;
                ref_tick  = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end
        if (ref_clear) begin
            ref_pend_d = 1'b0;
        end
        if (ref_tick) begin
            if (ref_pend_q && !ref_clear) begin
                missed_d = 1'b1;
            end
            ref_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            missed_q   <= missed_d;
        end
    end

    assign bus.refresh_missed = missed_q;
`else
    assign ref_want           = 1'b0;
    assign bus.refresh_missed = 1'b0;
`endif

    assign bus.c3_p0_cmd_en        = cmd_en_q;
    assign bus.c3_p0_cmd_instr     = instr_q;
    assign bus.c3_p0_cmd_bl        = bl_q;
    assign bus.c3_p0_cmd_byte_addr = {addr_q, 2'b00};
    assign bus.wr_ack              = wr_ack_q;
    assign bus.rd_ack              = rd_ack_q;
    assign bus.err                 = err_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Build with DDR_ARB_REFRESH_EN defined to also exercise the refresh injector (period 16).
module tb_ddr_cmd_arbiter;

    localparam int unsigned Period = 16;
`ifdef DDR_ARB_REFRESH_EN
    localparam bit RefEn = 1'b1;
`else
    localparam bit RefEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    ddr_cmd_arbiter_if bus ();

    ddr_cmd_arbiter #(
        .REFRESH_PERIOD (Period),
        .AUTO_PRECHARGE (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] out_vec();
        return {bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack, bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl,
                bus.c3_p0_cmd_byte_addr, bus.err, bus.refresh_missed};
    endfunction

    task automatic drive_idle();
        bus.c3_calib_done     = 1'b0;
        bus.wr_req            = 1'b0;
        bus.wr_bl             = '0;
        bus.wr_addr           = '0;
        bus.rd_req            = 1'b0;
        bus.rd_bl             = '0;
        bus.rd_addr           = '0;
        bus.c3_p0_cmd_full    = 1'b0;
        bus.c3_p0_wr_count    = '0;
        bus.c3_p0_wr_underrun = 1'b0;
        bus.c3_p0_rd_count    = '0;
        bus.c3_p0_rd_overflow = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.c3_calib_done  = 1'b1;
        bus.wr_req         = 1'b1;
        bus.c3_p0_wr_count = 7'd64;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_vec() !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, want 0", out_vec());
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        bus.c3_calib_done  = 1'b1;
        bus.wr_req         = 1'b1;
        bus.wr_bl          = 6'd5;
        bus.wr_addr        = 30'($urandom);
        bus.c3_p0_wr_count = 7'd64;
        @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.wr_ack} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_issue_pre: got en/ack %b, want 11", {bus.c3_p0_cmd_en, bus.wr_ack});
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.wr_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_issue_drop: got en/ack %b, want 00", {bus.c3_p0_cmd_en, bus.wr_ack});
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_calib_gate();
        logic [29:0] a;
        logic [5:0]  b;
        a = 30'($urandom);
        b = 6'($urandom_range(0, 63));
        do_reset();
        bus.wr_req         = 1'b1;
        bus.wr_bl          = b;
        bus.wr_addr        = a;
        bus.c3_p0_wr_count = 7'd64;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.c3_p0_cmd_en !== 1'b0 || bus.wr_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL calib_gate_hold: got en %b ack %b, want 0 0", bus.c3_p0_cmd_en,
                         bus.wr_ack);
            end
        end
        bus.c3_calib_done = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl, bus.c3_p0_cmd_byte_addr,
             bus.wr_ack, bus.rd_ack} !== {1'b1, 3'b010, b, a[29:2], 2'b00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL calib_gate_issue: got en %b instr %b bl %0d addr %h wack %b rack %b, want 1 010 %0d %h 1 0",
                     bus.c3_p0_cmd_en, bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl,
                     bus.c3_p0_cmd_byte_addr, bus.wr_ack, bus.rd_ack, b, {a[29:2], 2'b00});
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.wr_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL calib_gate_pulse: got en/ack %b, want 00", {bus.c3_p0_cmd_en, bus.wr_ack});
        end
    endtask

    task automatic test_wr_threshold();
        do_reset();
        bus.c3_calib_done  = 1'b1;
        bus.wr_req         = 1'b1;
        bus.wr_bl          = 6'd63;
        bus.wr_addr        = 30'($urandom);
        bus.c3_p0_wr_count = 7'd63;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.c3_p0_cmd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL wr_threshold_short: got en %b, want 0", bus.c3_p0_cmd_en);
            end
        end
        bus.c3_p0_wr_count = 7'd64;
        @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack, bus.c3_p0_cmd_bl} !== {3'b110, 6'd63}) begin
            miscompares++;
            $display("FAIL wr_threshold_full: got en/wack/rack %b bl %0d, want 110 63",
                     {bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack}, bus.c3_p0_cmd_bl);
        end
        bus.wr_req = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [5:0]  wb, rb;
        logic [29:0] wa, ra;
        bit          exp_en, exp_w;
        wb = 6'($urandom_range(0, 63));
        rb = 6'($urandom_range(0, 63));
        wa = 30'($urandom);
        ra = 30'($urandom);
        do_reset();
        bus.c3_calib_done  = 1'b1;
        bus.wr_req         = 1'b1;
        bus.wr_bl          = wb;
        bus.wr_addr        = wa;
        bus.rd_req         = 1'b1;
        bus.rd_bl          = rb;
        bus.rd_addr        = ra;
        bus.c3_p0_wr_count = 7'd64;
        bus.c3_p0_rd_count = 7'd0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_en = (i % 3 == 1);
            exp_w  = ((i - 1) / 3) % 2 == 0;
            vectors++;
            if ({bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack} !==
                {exp_en, exp_en && exp_w, exp_en && !exp_w}) begin
                miscompares++;
                $display("FAIL round_robin_c%0d: got en/wack/rack %b, want %b", i,
                         {bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack},
                         {exp_en, exp_en && exp_w, exp_en && !exp_w});
            end
            if (exp_en) begin
                vectors++;
                if ({bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl, bus.c3_p0_cmd_byte_addr} !==
                    (exp_w ? {3'b010, wb, wa[29:2], 2'b00} : {3'b011, rb, ra[29:2], 2'b00})) begin
                    miscompares++;
                    $display("FAIL round_robin_cmd%0d: got instr %b bl %0d addr %h, want winner %s",
                             i, bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl, bus.c3_p0_cmd_byte_addr,
                             exp_w ? "write" : "read");
                end
            end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_rd_threshold();
        do_reset();
        bus.c3_calib_done  = 1'b1;
        bus.rd_req         = 1'b1;
        bus.rd_bl          = 6'd31;
        bus.rd_addr        = 30'($urandom);
        bus.c3_p0_rd_count = 7'd40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.c3_p0_cmd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_threshold_full: got en %b, want 0", bus.c3_p0_cmd_en);
            end
        end
        bus.c3_p0_rd_count = 7'd32;
        @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.rd_ack, bus.wr_ack, bus.c3_p0_cmd_instr} !== {3'b110, 3'b011}) begin
            miscompares++;
            $display("FAIL rd_threshold_fit: got en/rack/wack %b instr %b, want 110 011",
                     {bus.c3_p0_cmd_en, bus.rd_ack, bus.wr_ack}, bus.c3_p0_cmd_instr);
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_cmd_full_err();
        do_reset();
        bus.c3_calib_done  = 1'b1;
        bus.c3_p0_cmd_full = 1'b1;
        bus.wr_req         = 1'b1;
        bus.rd_req         = 1'b1;
        bus.c3_p0_wr_count = 7'd64;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.c3_p0_cmd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL cmd_full_block: got en %b, want 0", bus.c3_p0_cmd_en);
            end
        end
        bus.c3_p0_cmd_full = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack} !== 3'b110) begin
            miscompares++;
            $display("FAIL cmd_full_release: got en/wack/rack %b, want 110",
                     {bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack});
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_before: got %b, want 0", bus.err);
        end
        bus.c3_p0_rd_overflow = 1'b1;
        @(negedge clk);
        bus.c3_p0_rd_overflow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_sticky: got %b, want 1", bus.err);
            end
            @(negedge clk);
        end
        do_reset();
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_reset: got %b, want 0", bus.err);
        end
    endtask

`ifdef DDR_ARB_REFRESH_EN
    task automatic test_refresh();
        do_reset();
        bus.c3_calib_done  = 1'b1;
        bus.c3_p0_cmd_full = 1'b1;
        bus.wr_req         = 1'b1;
        bus.wr_addr        = 30'($urandom);
        bus.c3_p0_wr_count = 7'd64;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 31) begin
                vectors++;
                if (bus.refresh_missed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL refresh_missed_early: got %b, want 0", bus.refresh_missed);
                end
            end
        end
        vectors++;
        if (bus.refresh_missed !== 1'b1) begin
            miscompares++;
            $display("FAIL refresh_missed_set: got %b, want 1", bus.refresh_missed);
        end
        bus.c3_p0_cmd_full = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack, bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl,
             bus.c3_p0_cmd_byte_addr} !== {3'b100, 3'b100, 6'd0, 30'd0}) begin
            miscompares++;
            $display("FAIL refresh_issue: got en/wack/rack %b instr %b bl %0d addr %h, want 100 100 0 0",
                     {bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack}, bus.c3_p0_cmd_instr,
                     bus.c3_p0_cmd_bl, bus.c3_p0_cmd_byte_addr);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.c3_p0_cmd_en, bus.wr_ack, bus.c3_p0_cmd_instr} !== {2'b11, 3'b010}) begin
            miscompares++;
            $display("FAIL refresh_then_client: got en/wack %b instr %b, want 11 010",
                     {bus.c3_p0_cmd_en, bus.wr_ack}, bus.c3_p0_cmd_instr);
        end
        bus.wr_req = 1'b0;
    endtask
`endif

    task automatic test_random();
        int          cool = 0, cal_edges = 0;
        bit          last_w = 1'b0, pend = 1'b0, missed = 1'b0, ref_iss = 1'b0, err_m = 1'b0;
        bit          wa = 1'b0, ra = 1'b0, we, re, tick, go, take_ref, take_w;
        logic [5:0]  wbl = '0, rbl = '0;
        logic [29:0] wad = '0, rad = '0;
        bit          e_en = 1'b0, e_wa = 1'b0, e_ra = 1'b0;
        logic [2:0]  e_instr = '0;
        logic [5:0]  e_bl = '0;
        logic [29:0] e_addr = '0;
        bit          calib, full, under, over;
        logic [6:0]  wc, rc;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            vectors++;
            if ({bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack, bus.err, bus.refresh_missed} !==
                {e_en, e_wa, e_ra, err_m, missed}) begin
                miscompares++;
                $display("FAIL random_ctrl@%0d: got en/wack/rack/err/missed %b, want %b", n,
                         {bus.c3_p0_cmd_en, bus.wr_ack, bus.rd_ack, bus.err, bus.refresh_missed},
                         {e_en, e_wa, e_ra, err_m, missed});
            end
            if (e_en) begin
                vectors++;
                if ({bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl, bus.c3_p0_cmd_byte_addr} !==
                    {e_instr, e_bl, e_addr}) begin
                    miscompares++;
                    $display("FAIL random_cmd@%0d: got instr %b bl %0d addr %h, want %b %0d %h", n,
                             bus.c3_p0_cmd_instr, bus.c3_p0_cmd_bl, bus.c3_p0_cmd_byte_addr,
                             e_instr, e_bl, e_addr);
                end
            end
            // Clients keep a request frozen until acked, then maybe post a new one.
            if (e_wa) wa = 1'b0;
            if (e_ra) ra = 1'b0;
            if (!wa && $urandom_range(0, 1) == 1) begin
                wa  = 1'b1;
                wbl = 6'($urandom_range(0, 63));
                wad = 30'($urandom);
            end
            if (!ra && $urandom_range(0, 1) == 1) begin
                ra  = 1'b1;
                rbl = 6'($urandom_range(0, 63));
                rad = 30'($urandom);
            end
            calib = ($urandom_range(0, 9) != 0);
            full  = ($urandom_range(0, 4) == 0);
            wc    = 7'($urandom_range(0, 64));
            rc    = 7'($urandom_range(0, 64));
            under = ($urandom_range(0, 299) == 0);
            over  = ($urandom_range(0, 299) == 0);
            bus.wr_req = wa;  bus.wr_bl = wbl;  bus.wr_addr = wad;
            bus.rd_req = ra;  bus.rd_bl = rbl;  bus.rd_addr = rad;
            bus.c3_calib_done = calib;  bus.c3_p0_cmd_full = full;
            bus.c3_p0_wr_count = wc;    bus.c3_p0_rd_count = rc;
            bus.c3_p0_wr_underrun = under;  bus.c3_p0_rd_overflow = over;

            we   = wa && (int'(wc) >= int'(wbl) + 1);
            re   = ra && (int'(rc) + int'(rbl) + 1 <= 64);
            tick = 1'b0;
            if (RefEn && calib) begin
                cal_edges++;
                tick = (cal_edges % Period == 0);
            end
            go       = (cool == 0) && calib && !full && (pend || we || re);
            take_ref = go && pend;
            take_w   = (we && re) ? !last_w : we;
            e_en = go;
            e_wa = 1'b0;
            e_ra = 1'b0;
            if (take_ref) begin
                e_instr = 3'b100;  e_bl = '0;  e_addr = '0;
            end else if (go && take_w) begin
                e_wa = 1'b1;  e_instr = 3'b010;  e_bl = wbl;  e_addr = {wad[29:2], 2'b00};
                last_w = 1'b1;
            end else if (go) begin
                e_ra = 1'b1;  e_instr = 3'b011;  e_bl = rbl;  e_addr = {rad[29:2], 2'b00};
                last_w = 1'b0;
            end
            if (tick && pend && !ref_iss) missed = 1'b1;
            if (tick) pend = 1'b1;
            else if (ref_iss) pend = 1'b0;
            ref_iss = take_ref;
            cool    = go ? 2 : (cool > 0 ? cool - 1 : 0);
            if (under || over) err_m = 1'b1;
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_reset_mid_issue();
        test_calib_gate();
        test_wr_threshold();
        test_round_robin();
        test_rd_threshold();
        test_cmd_full_err();
`ifdef DDR_ARB_REFRESH_EN
        test_refresh();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
